// File: rtl/rob_commit.sv
`default_nettype none
// ============================================================================
//  Module   : rob_commit
//  Purpose  : Reorder buffer with in-order retirement. Issue allocates entries
//             at the tail, two write-back ports complete entries out of order,
//             and the oldest completed entry retires one per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module rob_commit #(
   parameter int ROB_DEPTH = 8,
   parameter int TAG_W     = 3,
   parameter int DATA_W    = 16,
   parameter int REG_W     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              alloc_valid,
   input  logic [REG_W-1:0]  alloc_dest_reg,
   output logic              alloc_ready,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              wb0_valid,
   input  logic [TAG_W-1:0]  wb0_tag,
   input  logic [DATA_W-1:0] wb0_value,
   input  logic              wb1_valid,
   input  logic [TAG_W-1:0]  wb1_tag,
   input  logic [DATA_W-1:0] wb1_value,
   output logic              commit_valid,
   output logic [TAG_W-1:0]  commit_tag,
   output logic [REG_W-1:0]  commit_reg,
   output logic [DATA_W-1:0] commit_value,
   output logic [TAG_W:0]    rob_count
);

   localparam int                CNT_W      = TAG_W + 1;
   localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(ROB_DEPTH);

   logic [ROB_DEPTH-1:0] ent_valid;
   logic [ROB_DEPTH-1:0] ent_ready;
   logic [REG_W-1:0]     ent_dest  [ROB_DEPTH];
   logic [DATA_W-1:0]    ent_value [ROB_DEPTH];
   logic [TAG_W-1:0]     head;
   logic [TAG_W-1:0]     tail;
   logic [CNT_W-1:0]     count;

   logic alloc_fire;
   logic commit_fire;
   logic wb0_take;
   logic wb1_take;

   // Full check uses the registered count, so a same-edge commit cannot free a slot early.
   assign alloc_ready = (count < FULL_COUNT);
   assign alloc_tag   = tail;
   assign alloc_fire  = alloc_valid & alloc_ready;
   assign commit_fire = ent_valid[head] & ent_ready[head];

   // A write-back only lands on a live, still-pending entry; port 0 owns a shared tag.
   assign wb0_take = wb0_valid & ent_valid[wb0_tag] & ~ent_ready[wb0_tag];
   assign wb1_take = wb1_valid & ent_valid[wb1_tag] & ~ent_ready[wb1_tag]
                   & ~(wb0_valid & (wb0_tag == wb1_tag));

   assign rob_count = count;

   // Control state: entry flags, pointers, occupancy and the registered commit port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_valid    <= '0;
         ent_ready    <= '0;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         commit_valid <= 1'b0;
         commit_tag   <= '0;
         commit_reg   <= '0;
         commit_value <= '0;
      end else if (flush) begin
         ent_valid    <= '0;
         ent_ready    <= '0;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         commit_valid <= 1'b0;
         commit_tag   <= '0;
         commit_reg   <= '0;
         commit_value <= '0;
      end else begin
         // Head and tail can only coincide on a firing pair when full, and then
         // allocation is blocked, so these per-entry writes never collide.
         if (commit_fire) begin
            commit_valid    <= 1'b1;
            commit_tag      <= head;
            commit_reg      <= ent_dest[head];
            commit_value    <= ent_value[head];
            ent_valid[head] <= 1'b0;
            ent_ready[head] <= 1'b0;
            head            <= head + TAG_W'(1);
         end else begin
            commit_valid <= 1'b0;
         end
         if (alloc_fire) begin
            ent_valid[tail] <= 1'b1;
            ent_ready[tail] <= 1'b0;
            tail            <= tail + TAG_W'(1);
         end
         if (wb0_take) begin
            ent_ready[wb0_tag] <= 1'b1;
         end
         if (wb1_take) begin
            ent_ready[wb1_tag] <= 1'b1;
         end
         count <= count + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
      end
   end

   // Payload storage: destination and result values need no reset, the flags gate their use.
   always_ff @(posedge clk) begin
      if (alloc_fire && !flush) begin
         ent_dest[tail] <= alloc_dest_reg;
      end
      if (wb0_take && !flush) begin
         ent_value[wb0_tag] <= wb0_value;
      end
      if (wb1_take && !flush) begin
         ent_value[wb1_tag] <= wb1_value;
      end
   end

endmodule
`default_nettype wire

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer with in-order retirement stage, directly downstream of the write-back stage.
- Issue allocates an entry per instruction and receives a tag. Write-back ports mark entries ready and deposit result values.
- The commit port retires the oldest ready entry each cycle to the architectural register file.
- Replaces the ad-hoc rob_dest_reg_value / v_des / commit arrays with one owned block.

Parameters:
- ROB_DEPTH, 8, number of entries; must be a power of 2.
- TAG_W, 3, log2(ROB_DEPTH); width of ROB tags.
- DATA_W, 16, width of result values.
- REG_W, 3, architectural register index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all entries.
- alloc_valid  in  1  issue requests an entry this cycle.
- alloc_dest_reg  in  REG_W  destination register of the allocating instruction.
- alloc_ready  out  1  entry available (count < ROB_DEPTH); combinational.
- alloc_tag  out  TAG_W  tag the allocation receives; equals the tail pointer; combinational.
- wb0_valid  in  1  write-back port 0 strobe (res1 units).
- wb0_tag  in  TAG_W  entry being written by port 0.
- wb0_value  in  DATA_W  result on port 0.
- wb1_valid  in  1  write-back port 1 strobe (res2 unit).
- wb1_tag  in  TAG_W  entry being written by port 1.
- wb1_value  in  DATA_W  result on port 1.
- commit_valid  out  1  one-cycle retire pulse; registered.
- commit_tag  out  TAG_W  tag of the retired entry; registered.
- commit_reg  out  REG_W  destination register to write; registered.
- commit_value  out  DATA_W  value to write; registered.
- rob_count  out  TAG_W+1  occupied entries; registered.

Behaviour:
- Per-entry state: valid, ready, dest[REG_W], value[DATA_W]. Pointers: head, tail (TAG_W bits each, wrap modulo ROB_DEPTH). count (TAG_W+1 bits).
- Reset (async) and flush (sync) set identical state:
  - all valid=0, ready=0;
  - head=tail=0, count=0;
  - commit_valid=0, commit_tag=0, commit_reg=0, commit_value=0, rob_count=0.
- Flush has priority over alloc, write-back and commit in the same cycle.
- Allocation (alloc_valid & alloc_ready at the edge):
  - entry[tail] <= valid=1, ready=0, dest=alloc_dest_reg, value unchanged;
  - tail <= tail+1 (wraps 7->0).
  - alloc_valid while full is ignored; no state change.
- Write-back (each port, evaluated at the edge):
  - if entry[tag].valid & !entry[tag].ready: ready <= 1, value <= port value.
  - A write-back to an invalid or already-ready entry is ignored.
  - Both ports targeting the same tag: port 0 wins, port 1 is dropped.
  - A write-back in the same cycle as the allocation of that tag is ignored (entry not yet valid).
- Commit (evaluated on state registered before the edge):
  - if entry[head].valid & entry[head].ready: commit_valid <= 1, commit_tag <= head, commit_reg <= entry[head].dest, commit_value <= entry[head].value, entry[head].valid <= 0, entry[head].ready <= 0, head <= head+1;
  - else commit_valid <= 0 (other commit outputs hold).
  - At most one retirement per cycle; strictly in order. A ready younger entry waits behind a not-ready head.
- Latency: write-back sampled at edge E → commit_valid high in the cycle after edge E+1 at the earliest (1-cycle minimum).
- count <= count + (alloc accepted) - (commit fired); rob_count mirrors count.
- Full/simultaneous events: alloc_ready uses the registered count, so allocation is refused when full even if a commit fires the same edge. Simultaneous alloc and commit when not full leaves count unchanged.
- Empty: head==tail and count==0; no commit. Full: count==ROB_DEPTH with head==tail.
- Reset asserted mid-operation clears everything immediately; in-flight write-backs are lost.

Test Plan:
- Reset, then alloc 3 entries (dest r1, r2, r3) → alloc_tag 0, 1, 2, rob_count=3. Write back tag 0 value 16'h00AA → commit_valid with tag 0, r1, 16'h00AA one cycle later; rob_count=2.
- Out-of-order completion: write back tag 2 (16'h0003), then tag 1 (16'h0002) → commits occur in order: tag 1 (16'h0002) then tag 2 (16'h0003) on consecutive cycles.
- Fill: 8 allocs → alloc_ready=0, rob_count=8. A 9th alloc is ignored. Commit one → alloc_ready=1 and the next alloc gets tag 0 (wrap-around).
- Same-tag collision: wb0 and wb1 both tag 4 in one cycle (16'h1111 / 16'h2222) → committed value 16'h1111. A later wb to tag 4 is ignored.
- Flush with 5 live entries and a wb in the same cycle → rob_count=0, commit_valid=0, next alloc_tag=0.
- Async rst pulse between clock edges with 4 entries → all outputs 0 immediately, without waiting for a clock edge.
